// File: rtl/rv_core_pkg.sv
// Shared definitions for the RV32I core front end: widths, the fetch FSM
// state type and the default reset PC.
package rv_core_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Sequential successor of a fetch address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

endpackage

// File: rtl/ifetch_hold_buf.sv
// One-entry {data, pc, valid} buffer that parks a fetched word while the
// decoder's output slot is still occupied. Flush wins over load and unload.
module ifetch_hold_buf
  import rv_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] data_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
);

  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (unload_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      data_d  = data_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I instruction fetch: PC, one-outstanding imem requests, output register
// feeding the decoder, hold buffer for backpressure, redirect flush.
// Optional misaligned-redirect check: define IFETCH_MISALIGN_CHECK_EN.
module instruction_fetch
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic [XLEN-1:0] instruction_code,
  output logic            en,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_misaligned,
  output fetch_state_e    dbg_state
);

  // Handshakes: a request transfers on a cycle with imem_req_valid &&
  // imem_req_ready; a response is taken whenever imem_resp_valid is high;
  // the output is consumed on a cycle with en && id_ready.

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            en_q, en_d;
  logic [XLEN-1:0] code_q, code_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            mis_q, mis_d;

  logic            hb_load, hb_unload, hb_flush, hb_valid;
  logic [XLEN-1:0] hb_data, hb_pc;

  logic [XLEN-1:0] redirect_target;
  logic            redirect_mis;
  logic            req_block;
  logic            req_fire;
  logic            slot_free;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign redirect_target = redirect_pc;
  assign redirect_mis    = |redirect_pc[1:0];
  assign req_block       = mis_q;
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign redirect_mis        = 1'b0;
  assign req_block           = 1'b0;
`endif

  assign imem_req_valid = (state_q == FETCH) && !req_block;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign slot_free      = !en_q || id_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    en_d      = en_q;
    code_d    = code_q;
    ipc_d     = ipc_q;
    mis_d     = mis_q;
    hb_load   = 1'b0;
    hb_unload = 1'b0;
    hb_flush  = 1'b0;

    if (en_q && id_ready) begin
      en_d = 1'b0;
    end

    unique case (state_q)
      FETCH: begin
        if (req_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else if (slot_free) begin
            code_d  = imem_resp_data;
            ipc_d   = pc_q;
            en_d    = 1'b1;
            pc_d    = next_pc(pc_q);
            state_d = FETCH;
          end else begin
            hb_load = 1'b1;
            pc_d    = next_pc(pc_q);
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (id_ready && hb_valid) begin
          code_d    = hb_data;
          ipc_d     = hb_pc;
          en_d      = 1'b1;
          hb_unload = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // A request still in flight after a redirect must have its word dropped.
    if (redirect_valid) begin
      pc_d     = redirect_target;
      mis_d    = redirect_mis;
      en_d     = 1'b0;
      hb_flush = 1'b1;
      if ((state_q == FETCH && req_fire) || (state_q == WAIT && !imem_resp_valid)) begin
        state_d = WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = FETCH;
        drop_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      en_q    <= 1'b0;
      code_q  <= '0;
      ipc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      en_q    <= en_d;
      code_q  <= code_d;
      ipc_q   <= ipc_d;
      mis_q   <= mis_d;
    end
  end

  ifetch_hold_buf u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .load_i   (hb_load),
    .unload_i (hb_unload),
    .flush_i  (hb_flush),
    .data_i   (imem_resp_data),
    .pc_i     (pc_q),
    .data_o   (hb_data),
    .pc_o     (hb_pc),
    .valid_o  (hb_valid)
  );

  assign instruction_code = code_q;
  assign en               = en_q;
  assign inst_pc          = ipc_q;
  assign fetch_misaligned = mis_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model with configurable latency, an
// instruction-stream model checked every cycle, and directed scenarios.
module tb_instruction_fetch;
  import rv_core_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef IFETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_resp_valid;
  logic [31:0]  imem_resp_data;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         id_ready;
  logic [31:0]  instruction_code;
  logic         en;
  logic [31:0]  inst_pc;
  logic         fetch_misaligned;
  fetch_state_e dbg_state;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .id_ready         (id_ready),
    .instruction_code (instruction_code),
    .en               (en),
    .inst_pc          (inst_pc),
    .fetch_misaligned (fetch_misaligned),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cycle, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // ---------------- memory model ----------------
  int          mem_lat = 1;
  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_addr;
  logic        s_fire, s_rst;
  logic [31:0] s_addr;

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    m_pend = 1'b0;
    m_cnt  = 0;
    m_addr = '0;
    forever begin
      @(negedge clk);
      s_fire = imem_req_valid && imem_req_ready;
      s_addr = imem_req_addr;
      s_rst  = rst;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (s_rst) begin
        m_pend = 1'b0;
      end else begin
        if (s_fire) begin
          m_pend = 1'b1;
          m_cnt  = mem_lat;
          m_addr = s_addr;
        end
        if (m_pend) begin
          m_cnt--;
          if (m_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(m_addr);
            m_pend = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / stream model ----------------
  // exp_q holds PCs of fetched-but-undelivered instructions, oldest first.
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  bit          m_out, m_stale, m_mis;
  logic [31:0] req_log[$];
  logic [31:0] del_log[$];
  int          first_en = -1;
  int          rel_cycle = 0;

  initial begin
    exp_next = RST_PC;
    m_out = 1'b0; m_stale = 1'b0; m_mis = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        exp_q.delete();
        exp_next = RST_PC;
        m_out = 1'b0; m_stale = 1'b0; m_mis = 1'b0;
      end else begin
        check1("req_valid", imem_req_valid, !m_out && exp_q.size() < 2 && !m_mis);
        if (imem_req_valid) check32("req_addr", imem_req_addr, exp_next);
        check1("en", en, exp_q.size() > 0);
        if (en && exp_q.size() > 0) begin
          check32("inst_pc", inst_pc, exp_q[0]);
          check32("instruction_code", instruction_code, mem_word(exp_q[0]));
        end
        check1("fetch_misaligned", fetch_misaligned, m_mis);

        if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
        if (en) begin
          if (first_en < 0) first_en = cycle;
          if (id_ready) del_log.push_back(inst_pc);
        end

        if (en && id_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (imem_resp_valid && m_out) begin
          if (!m_stale && !redirect_valid) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
          end
          m_out = 1'b0;
        end
        if (redirect_valid) begin
          if (m_out) m_stale = 1'b1;
          exp_q.delete();
          exp_next = MIS_EN ? redirect_pc : {redirect_pc[31:2], 2'b00};
          m_mis    = MIS_EN && (redirect_pc[1:0] != 2'b00);
        end
        if (imem_req_valid && imem_req_ready) begin
          m_out   = 1'b1;
          m_stale = redirect_valid;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    req_log.delete();
    del_log.delete();
    first_en  = -1;
    rel_cycle = cycle + 1;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the test sequence");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1;
    id_ready = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Reset and sequential fetch, zero-wait memory.
    mem_lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
    do_reset();
    check1("reset_en", en, 1'b0);
    check32("reset_instruction_code", instruction_code, 32'h0);
    check32("reset_inst_pc", inst_pc, 32'h0);
    check1("reset_misaligned", fetch_misaligned, 1'b0);
    check32("reset_state", 32'(dbg_state), 32'(FETCH));
    check1("first_req_valid", imem_req_valid, 1'b1);
    check32("reset_req_addr", imem_req_addr, 32'h100);
    repeat (10) tick();
    check32("seq_first_en_latency", 32'(first_en - rel_cycle), 32'd2);
    check32("seq_req0", q_at(req_log, 0), 32'h100);
    check32("seq_req1", q_at(req_log, 1), 32'h104);
    check32("seq_req2", q_at(req_log, 2), 32'h108);
    check32("seq_del0", q_at(del_log, 0), 32'h100);
    check32("seq_del2", q_at(del_log, 2), 32'h108);

    // Backpressure: second word parks in HOLD, no third request.
    id_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    check32("bp_req_count", 32'(req_log.size()), 32'd2);
    check32("bp_del_count", 32'(del_log.size()), 32'd0);
    id_ready = 1'b1;
    repeat (10) tick();
    check32("bp_del0", q_at(del_log, 0), 32'h100);
    check32("bp_del1", q_at(del_log, 1), 32'h104);
    check32("bp_del2", q_at(del_log, 2), 32'h108);

    // Redirect while a 3-cycle response is pending.
    mem_lat = 3; id_ready = 1'b1;
    do_reset();
    tick();
    pulse_redirect(32'h200);
    repeat (20) tick();
    check32("rw_req0", q_at(req_log, 0), 32'h100);
    check32("rw_req1", q_at(req_log, 1), 32'h200);
    check32("rw_del0", q_at(del_log, 0), 32'h200);

    // Redirect in the same cycle as the response.
    mem_lat = 1;
    do_reset();
    tick();
    pulse_redirect(32'h300);
    check1("coinc_no_en", en, 1'b0);
    repeat (8) tick();
    check32("coinc_req1", q_at(req_log, 1), 32'h300);
    check32("coinc_del0", q_at(del_log, 0), 32'h300);

    // Redirect with a coincident request, then PC wrap.
    do_reset();
    pulse_redirect(32'hFFFF_FFFC);
    repeat (10) tick();
    check32("wrap_req1", q_at(req_log, 1), 32'hFFFF_FFFC);
    check32("wrap_req2", q_at(req_log, 2), 32'h0000_0000);
    check32("wrap_del0", q_at(del_log, 0), 32'hFFFF_FFFC);
    check32("wrap_del1", q_at(del_log, 1), 32'h0000_0000);

    // Misaligned redirect target, memory not ready at the time.
    imem_req_ready = 1'b0;
    do_reset();
    pulse_redirect(32'h202);
    imem_req_ready = 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
    repeat (5) tick();
    check1("mis_flag_set", fetch_misaligned, 1'b1);
    check32("mis_no_req", 32'(req_log.size()), 32'd0);
    pulse_redirect(32'h300);
    repeat (8) tick();
    check1("mis_flag_clear", fetch_misaligned, 1'b0);
    check32("mis_req0", q_at(req_log, 0), 32'h300);
    check32("mis_del0", q_at(del_log, 0), 32'h300);
`else
    repeat (8) tick();
    check1("mis_flag_tied", fetch_misaligned, 1'b0);
    check32("mis_req0", q_at(req_log, 0), 32'h200);
    check32("mis_del0", q_at(del_log, 0), 32'h200);
`endif

    // Redirect while a word is parked in the hold buffer.
    id_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    pulse_redirect(32'h400);
    check1("hold_flush_en", en, 1'b0);
    id_ready = 1'b1;
    repeat (10) tick();
    check32("hold_flush_del0", q_at(del_log, 0), 32'h400);
    check32("hold_flush_del1", q_at(del_log, 1), 32'h404);

    // Mixed request stalls and decode backpressure, 2-cycle memory.
    mem_lat = 2;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      imem_req_ready = (i % 3) != 0;
      id_ready       = (i % 4) != 1;
      tick();
    end
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    repeat (6) tick();
    check32("mix_del0", q_at(del_log, 0), 32'h100);
    check32("mix_del1", q_at(del_log, 1), 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage for the RV32I core, directly upstream of `instruction_decoder`. It holds the PC and issues one-outstanding requests to instruction memory. Returned words are buffered into an output register that drives the decoder's `instruction_code` and `en` inputs. Backpressure from decode is absorbed by a one-entry hold buffer, and branch/jump redirects from execute flush everything in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_req_addr` output 32: fetch address; always equals `pc`.
- `imem_resp_valid` input 1: response data valid. It is never backpressured and is always accepted.
- `imem_resp_data` input 32: fetched instruction word.
- `redirect_valid` input 1: one-cycle pulse to restart fetch at `redirect_pc`.
- `redirect_pc` input 32: new fetch target.
- `id_ready` input 1: decode consumes the current output this cycle when `en` is high.
- `instruction_code` output 32: instruction to the decoder.
- `en` output 1: `instruction_code`/`inst_pc` valid; drives decoder `en`.
- `inst_pc` output 32: PC of `instruction_code`.
- `fetch_misaligned` output 1: misaligned redirect target detected (see Configuration).

## Operation
- The state machine has three states: FETCH, WAIT, HOLD.
- **FETCH**
  - `imem_req_valid`=1, unless the fetch is blocked (see Configuration).
  - On `imem_req_valid && imem_req_ready`, go to WAIT.
- **WAIT**
  - `imem_req_valid`=0.
  - On `imem_resp_valid` with `drop`=1: discard the word, clear `drop`, go to FETCH.
  - On `imem_resp_valid` with `drop`=0 and the output slot free (`!en || id_ready`):
    - load `instruction_code`←data, `inst_pc`←`pc`, `en`←1;
    - `pc`←`pc`+4 (mod 2^32, wraps 0xFFFF_FFFC→0);
    - go to FETCH.
  - On `imem_resp_valid` with `drop`=0 and the slot full and not consumed:
    - store data and `pc` into the hold buffer;
    - `pc`←`pc`+4;
    - go to HOLD.
- **HOLD**
  - `imem_req_valid`=0.
  - On `id_ready`: move the hold buffer into the output register (`en` stays 1), go to FETCH.
- **Output consumption**: `en && id_ready` with no new load in the same cycle clears `en`.
- **Redirect** (priority: `rst` > redirect > normal operation):
  - `pc`←`redirect_pc`, `en`←0, hold buffer invalidated, next state FETCH.
  - Redirect in WAIT with no same-cycle response: set `drop`=1, stay in WAIT.
  - Redirect coincident with a FETCH handshake: the request counts as outstanding; go to WAIT with `drop`=1.
  - Redirect coincident with a response in WAIT: the response is discarded; go to FETCH with `drop`=0.
- **Reset**
  - Values: `pc`=`RESET_PC`, state FETCH, `en`=0, `instruction_code`=0, `inst_pc`=0, `drop`=0, hold buffer empty, `fetch_misaligned`=0.
  - A mid-operation reset abandons any outstanding request. Memory must also be reset by the same `rst`.

## Timing
- `imem_req_valid` and `imem_req_addr` are combinational from state and `pc`.
- All other outputs are registered.
- Response in cycle N → `en`=1 and `instruction_code` visible in cycle N+1.
- Peak throughput is one instruction per 2 cycles (FETCH, WAIT) with zero-wait memory.
- First request is asserted in the first cycle after `rst` deasserts.
- Redirect in cycle N → `en`=0 in N+1, and a request to `redirect_pc` in N+1 (FETCH) or after the dropped response.
- At most one request is outstanding at any time.
- Output and hold registers retain their value while `en && !id_ready`.

## Configuration
- The misaligned-redirect check is selected by the macro `IFETCH_MISALIGN_CHECK_EN`.
- **Defined**:
  - a redirect with `redirect_pc[1:0]`≠0 loads `pc` and sets `fetch_misaligned`=1;
  - while the flag is set, `imem_req_valid` is forced to 0;
  - the flag clears on the next aligned redirect or on reset.
- **Undefined**:
  - `redirect_pc[1:0]` is ignored (`pc` low bits forced to 00);
  - `fetch_misaligned` is tied to 0.

## Structure
- Shared package `rv_core_pkg` holds:
  - the fetch state enum (FETCH/WAIT/HOLD);
  - `XLEN`=32;
  - `INST_BYTES`=4;
  - the default `RESET_PC` constant.
- Sub-module `ifetch_hold_buf`: one-entry {data, pc, valid} register with load/unload/flush controls, used for the HOLD path.

## Test plan
- **Reset/sequential fetch**: `RESET_PC`=0x100, zero-wait memory, `id_ready`=1 → requests at 0x100, 0x104, 0x108; `en` pulses with matching `inst_pc`; first `en` 2 cycles after reset release.
- **Backpressure**: `id_ready`=0 for 6 cycles after the first instruction → second word enters HOLD, no third request issued; on `id_ready`=1 both instructions emerge in order, none lost or duplicated.
- **Redirect in WAIT**: redirect to 0x200 while a response is pending with 3-cycle latency → stale word dropped; next `en` has `inst_pc`=0x200.
- **Redirect coincident with response**: response and `redirect_valid` in the same cycle → no `en`; next request address is `redirect_pc`.
- **PC wrap**: redirect to 0xFFFF_FFFC → next request address 0x0000_0000.
- **Misaligned target** (`IFETCH_MISALIGN_CHECK_EN` defined): redirect to 0x202 → `fetch_misaligned`=1, no requests; then redirect to 0x300 → flag clears and fetch resumes at 0x300.
